lc3_trace_mon: RTL and testbench

//   Parametrised run-control and trace monitor attached to the lc3_datapath

---
 rtl/lc3_trace_mon.sv | 169 ++++++++++++++++
 tb/tb_lc3_trace_mon.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_trace_mon.sv
// LC-3 run-control and trace monitor: breakpoints, halt/step FSM and a
// {ts, pc, ir, nzp} trace FIFO fed from the datapath debug taps.
//
// Ports:
//   clk, rst (async, active low)
//   pc, ir, ld_ir, bus, ld_cc        : datapath taps
//   trc_en                           : trace capture enable
//   bp_en, bp_mode, bp_addr          : breakpoint configuration
//   halt_clr, step_req               : run-control pulses
//   rd_en                            : FIFO pop request
//   rd_data, rd_valid                : popped entry and its 1-cycle strobe
//   empty, full, level, ovf_cnt      : FIFO status and drop counter
//   bp_hit, halt_req                 : sticky hit flags and datapath stall
module lc3_trace_mon #(
    parameter int DEPTH  = 16,
    parameter int NUM_BP = 2,
    parameter int TS_W   = 16,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              pc,
    input  logic [15:0]              ir,
    input  logic                     ld_ir,
    input  logic [15:0]              bus,
    input  logic                     ld_cc,
    input  logic                     trc_en,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP-1:0]        bp_mode,
    input  logic [16*NUM_BP-1:0]     bp_addr,
    input  logic                     halt_clr,
    input  logic                     step_req,
    input  logic                     rd_en,
    output logic [TS_W+34:0]         rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic [NUM_BP-1:0]        bp_hit,
    output logic                     halt_req
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_W + 35;

    typedef enum logic [1:0] {S_RUN, S_HALTED, S_STEP} state_e;

    state_e             state_q;
    logic [TS_W-1:0]    ts_q;
    logic [2:0]         nzp_q, nzp_d;
    logic [AW:0]        wr_q, rd_q;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      rd_data_q;
    logic               rd_valid_q;
    logic [CNT_W-1:0]   ovf_q;
    logic [NUM_BP-1:0]  hit_q, hit_d;
    logic               halt_q;
    logic               push_req, pop_ok, push_ok, drop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level = wr_q - rd_q;

    // A pop on an empty FIFO is ignored; a pop frees room for a push when full.
    assign push_req = ld_ir && trc_en;
    assign pop_ok   = rd_en && !empty;
    assign push_ok  = push_req && (!full || pop_ok);
    assign drop     = push_req && full && !pop_ok;

    always_comb begin
        nzp_d = 3'b001;
        if (bus[15])
            nzp_d = 3'b100;
        else if (bus == 16'h0000)
            nzp_d = 3'b010;
    end

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_mode[i])
                hit_d[i] = bp_en[i] && (pc >= bp_addr[16*i +: 16]);
            else
                hit_d[i] = bp_en[i] && (pc == bp_addr[16*i +: 16]);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_q[AW-1:0]] <= {ts_q, pc, ir, nzp_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            nzp_q      <= 3'b010;
            wr_q       <= '0;
            rd_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            ts_q       <= ts_q + 1'b1;
            rd_valid_q <= pop_ok;
            if (ld_cc)
                nzp_q <= nzp_d;
            if (push_ok)
                wr_q <= wr_q + 1'b1;
            if (pop_ok) begin
                rd_q      <= rd_q + 1'b1;
                rd_data_q <= mem_q[rd_q[AW-1:0]];
            end
            if (drop && (ovf_q != '1))
                ovf_q <= ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            hit_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (halt_clr) begin
                        hit_q <= '0;
                    end else if (ld_ir && (hit_d != '0)) begin
                        hit_q   <= hit_q | hit_d;
                        state_q <= S_HALTED;
                        halt_q  <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (halt_clr) begin
                        hit_q   <= '0;
                        state_q <= S_RUN;
                        halt_q  <= 1'b0;
                    end else if (step_req) begin
                        state_q <= S_STEP;
                        halt_q  <= 1'b0;
                    end
                end
                S_STEP: begin
                    // Breakpoints are ignored here so a step leaves a bp address.
                    if (halt_clr) begin
                        hit_q   <= '0;
                        state_q <= S_RUN;
                    end else if (ld_ir) begin
                        state_q <= S_HALTED;
                        halt_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    halt_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf_cnt  = ovf_q;
    assign bp_hit   = hit_q;
    assign halt_req = halt_q;

endmodule

// File: tb/tb_lc3_trace_mon.sv
// Self-checking bench for lc3_trace_mon: directed scenarios plus a
// randomized FIFO/nzp run against a queue-based reference model.
module tb_lc3_trace_mon;

    localparam int DEPTH = 16;
    localparam int EW    = 51;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc, ir, bus;
    logic        ld_ir, ld_cc, trc_en;
    logic [1:0]  bp_en, bp_mode;
    logic [15:0] bp_a0, bp_a1;
    logic        halt_clr, step_req, rd_en;
    logic [EW-1:0] rd_data;
    logic        rd_valid, empty, full, halt_req;
    logic [4:0]  level;
    logic [7:0]  ovf_cnt;
    logic [1:0]  bp_hit;

    int errors = 0;
    int checks = 0;

    logic [EW-1:0] mq[$];
    logic [EW-1:0] m_rd;
    logic          m_valid;
    logic [7:0]    m_ovf;
    logic [2:0]    m_nzp;
    logic [15:0]   m_ts;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) m_ts <= 16'd0;
        else      m_ts <= m_ts + 16'd1;

    lc3_trace_mon dut (
        .clk(clk), .rst(rst), .pc(pc), .ir(ir), .ld_ir(ld_ir),
        .bus(bus), .ld_cc(ld_cc), .trc_en(trc_en),
        .bp_en(bp_en), .bp_mode(bp_mode), .bp_addr({bp_a1, bp_a0}),
        .halt_clr(halt_clr), .step_req(step_req), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .full(full), .level(level), .ovf_cnt(ovf_cnt),
        .bp_hit(bp_hit), .halt_req(halt_req)
    );

    task automatic model_reset();
        mq.delete();
        m_rd    = '0;
        m_valid = 1'b0;
        m_ovf   = '0;
        m_nzp   = 3'b010;
    endtask

    // Advance the FIFO model by one clock with the inputs now applied,
    // then move to just after the edge.
    task automatic tick();
        logic          pop_ok;
        logic [EW-1:0] e;
        pop_ok  = rd_en && (mq.size() > 0);
        e       = {m_ts, pc, ir, m_nzp};
        m_valid = 1'b0;
        if (pop_ok) begin
            m_rd    = mq.pop_front();
            m_valid = 1'b1;
        end
        if (ld_ir && trc_en) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else if (m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
        end
        if (ld_cc) begin
            if (bus[15])        m_nzp = 3'b100;
            else if (bus == 0)  m_nzp = 3'b010;
            else                m_nzp = 3'b001;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc = 0; ir = 0; bus = 0; ld_ir = 0; ld_cc = 0; trc_en = 0;
        bp_en = 0; bp_mode = 0; bp_a0 = 0; bp_a1 = 0;
        halt_clr = 0; step_req = 0; rd_en = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", halt_req); end
        checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovf got %0d want 0", ovf_cnt); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (bp_hit !== 2'b00) begin errors++; $display("FAIL reset_bp_hit got %b want 00", bp_hit); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_trace();
        logic [15:0] prev_ts;
        trc_en = 1;
        ld_ir = 1; pc = 16'h3000; ir = 16'h1021; tick();
        ld_ir = 0; ld_cc = 1; bus = 16'h0000; tick();
        ld_cc = 0; ld_ir = 1; pc = 16'h3001; ir = 16'h5260; tick();
        pc = 16'h3002; ir = 16'h0FFE; tick();
        ld_ir = 0;
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL trace_level got %0d want 3", level); end
        prev_ts = 0;
        for (int k = 0; k < 3; k++) begin
            rd_en = 1; tick();
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL trace_valid%0d got %b want 1", k, rd_valid); end
            checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL trace_data%0d got %h want %h", k, rd_data, m_rd); end
            checks++; if (rd_data[2:0] !== 3'b010) begin errors++; $display("FAIL trace_nzp%0d got %b want 010", k, rd_data[2:0]); end
            if (k > 0) begin
                checks++;
                if (rd_data[50:35] <= prev_ts) begin errors++; $display("FAIL trace_ts%0d got %0d want > %0d", k, rd_data[50:35], prev_ts); end
            end
            prev_ts = rd_data[50:35];
        end
        rd_en = 1; tick(); rd_en = 0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL trace_pop_empty got %b want 0", rd_valid); end
        checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL trace_hold got %h want %h", rd_data, m_rd); end
        trc_en = 0;
    endtask

    task automatic test_overflow();
        trc_en = 1; ld_ir = 1;
        for (int k = 0; k < 20; k++) begin
            pc = 16'h4000 + 16'(k); ir = 16'($urandom); tick();
        end
        ld_ir = 0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", full); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", level); end
        checks++; if (ovf_cnt !== 8'd4) begin errors++; $display("FAIL ovf_cnt got %0d want 4", ovf_cnt); end
        ld_ir = 1; rd_en = 1; pc = 16'h4100; tick();
        ld_ir = 0; rd_en = 0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_pushpop_level got %0d want 16", level); end
        checks++; if (ovf_cnt !== 8'd4) begin errors++; $display("FAIL ovf_pushpop_cnt got %0d want 4", ovf_cnt); end
        checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL ovf_pushpop_data got %h want %h", rd_data, m_rd); end
        rd_en = 1;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++; if (rd_data !== m_rd || rd_valid !== 1'b1) begin
                errors++; $display("FAIL ovf_drain%0d got %h/%b want %h/1", k, rd_data, rd_valid, m_rd); end
        end
        rd_en = 0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got %b want 1", empty); end
        trc_en = 0;
    endtask

    task automatic test_breakpoint();
        bp_en = 2'b01; bp_mode = 2'b00; bp_a0 = 16'h3008; bp_a1 = 16'h3004;
        ld_ir = 1; pc = 16'h3007; tick();
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL bp_eq_miss got %b want 0", halt_req); end
        pc = 16'h3004; tick();
        checks++; if (bp_hit !== 2'b00) begin errors++; $display("FAIL bp_disabled got %b want 00", bp_hit); end
        pc = 16'h3008; tick(); ld_ir = 0;
        checks++; if (bp_hit !== 2'b01) begin errors++; $display("FAIL bp_eq_hit got %b want 01", bp_hit); end
        checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL bp_eq_halt got %b want 1", halt_req); end
        halt_clr = 1; tick(); halt_clr = 0;
        checks++; if (halt_req !== 1'b0 || bp_hit !== 2'b00) begin
            errors++; $display("FAIL bp_clr got %b/%b want 0/00", halt_req, bp_hit); end
        bp_mode = 2'b01; bp_a0 = 16'h3005;
        ld_ir = 1; pc = 16'h3004; tick();
        checks++; if (bp_hit !== 2'b00 || halt_req !== 1'b0) begin
            errors++; $display("FAIL bp_ge_below got %b/%b want 00/0", bp_hit, halt_req); end
        pc = 16'h3005; tick(); ld_ir = 0;
        checks++; if (bp_hit !== 2'b01 || halt_req !== 1'b1) begin
            errors++; $display("FAIL bp_ge_hit got %b/%b want 01/1", bp_hit, halt_req); end
        halt_clr = 1; tick(); halt_clr = 0;
        bp_en = 0;
    endtask

    task automatic test_step();
        bp_en = 2'b01; bp_mode = 2'b00; bp_a0 = 16'h3008; bp_a1 = 16'h0000;
        ld_ir = 1; pc = 16'h3008; tick(); ld_ir = 0;
        checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL step_halted got %b want 1", halt_req); end
        bp_en = 2'b11; bp_a1 = 16'h3008;
        step_req = 1; tick(); step_req = 0;
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL step_release got %b want 0", halt_req); end
        tick();
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL step_wait got %b want 0", halt_req); end
        ld_ir = 1; pc = 16'h3008; tick(); ld_ir = 0;
        checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL step_rehalt got %b want 1", halt_req); end
        checks++; if (bp_hit !== 2'b01) begin errors++; $display("FAIL step_no_retrig got %b want 01", bp_hit); end
        halt_clr = 1; step_req = 1; tick(); halt_clr = 0; step_req = 0;
        checks++; if (halt_req !== 1'b0 || bp_hit !== 2'b00) begin
            errors++; $display("FAIL step_clr got %b/%b want 0/00", halt_req, bp_hit); end
        bp_en = 0; ld_ir = 1; pc = 16'h1234; tick(); ld_ir = 0;
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL step_run got %b want 0", halt_req); end
    endtask

    task automatic test_async_reset();
        trc_en = 1; bp_en = 2'b01; bp_mode = 2'b00; bp_a0 = 16'h3008;
        ld_ir = 1;
        for (int k = 0; k < 5; k++) begin
            pc = 16'h3004 + 16'(k); tick();
        end
        ld_ir = 0; trc_en = 0; bp_en = 0;
        checks++; if (level !== 5'd5 || halt_req !== 1'b1) begin
            errors++; $display("FAIL arst_pre got %0d/%b want 5/1", level, halt_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty got %b want 1", empty); end
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL arst_halt got %b want 0", halt_req); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL arst_level got %0d want 0", level); end
        checks++; if (bp_hit !== 2'b00) begin errors++; $display("FAIL arst_bp_hit got %b want 00", bp_hit); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int pp;
            pp     = (c < 200) ? 75 : 25;
            ld_ir  = ($urandom_range(99) < pp);
            trc_en = ($urandom_range(9) != 0);
            rd_en  = ($urandom_range(99) >= pp);
            ld_cc  = $urandom_range(1);
            case ($urandom_range(2))
                0: bus = 16'h0000;
                1: bus = 16'h8000 | 16'($urandom);
                default: bus = 16'($urandom) & 16'h7FFF;
            endcase
            pc = 16'($urandom); ir = 16'($urandom);
            tick();
            checks++;
            if (rd_valid !== m_valid || rd_data !== m_rd || level !== 5'(mq.size()) ||
                empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
                ovf_cnt !== m_ovf) begin
                errors++;
                $display("FAIL rand%0d got v%b d%h l%0d e%b f%b o%0d want v%b d%h l%0d o%0d",
                         c, rd_valid, rd_data, level, empty, full, ovf_cnt,
                         m_valid, m_rd, mq.size(), m_ovf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_trace();
        test_overflow();
        test_breakpoint();
        test_step();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
